projectile: RTL and testbench
=============================

# projectile

Responder side of the throw handshake. It accepts a launch request (`throw_flag` plus `power`) from the throw controller and animates the projectile across the screen with integer ballistic physics. It detects target, wall, ground and out-of-screen collisions, then returns `end_throw` so the throw controller can re-arm. It sits between the throw controller and the sprite draw / scoring logic; its position outputs feed the projectile sprite.

## Interface
Parameters:
- `TICK_CYCLES`, 1_000_000: clk cycles per physics step (60 Hz at 60 MHz).
- `START_X_P1`, 100: launch x when player 1 throws.
- `START_X_P2`, 900: launch x when player 2 throws.
- `START_Y`, 600: launch y for both players.
- `GROUND_Y`, 700: flight ends when y ≥ this.
- `WALL_X_MIN`, 496; `WALL_X_MAX`, 528; `WALL_TOP`, 400: central wall box, inclusive; runs from `WALL_TOP` down to `GROUND_Y`.
- `TGT_HALF`, 32; `TGT_TOP`, 560: opponent target box is x ∈ [start_x ± TGT_HALF], y ∈ [TGT_TOP, GROUND_Y].

Ports:
- `clk60MHz`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `throw_flag`  in  1  launch request; level, held by the thrower until `end_throw`.
- `power`  in  5  launch power, sampled at launch only.
- `turn`  in  1  0: player 1 throws rightwards; 1: player 2 throws leftwards.
- `proj_x`  out  12  signed projectile x.
- `proj_y`  out  12  signed projectile y.
- `proj_visible`  out  1  projectile is drawn.
- `end_throw`  out  1  flight finished; held until `throw_flag` is seen low.
- `hit`  out  1  the finished flight struck the opponent target; valid while `end_throw` = 1.

## Operation
- State machine: IDLE → FLY → STEP → CHECK → (FLY | DONE) → IDLE.
- **IDLE:** `end_throw` = 0, `proj_visible` = 0.
  - On `throw_flag` = 1, latch `turn` and `power`, then go to FLY.
  - Launch values:
    - x = START_X_P1 if `turn` = 0, else START_X_P2.
    - y = START_Y.
    - vx = ±((power>>1)+2): sign + when `turn` = 0, − when `turn` = 1.
    - vy = −(power+4).
    - tick counter = 0.
  - Set `proj_visible` = 1.
- **FLY:** the counter increments each cycle; when it reaches TICK_CYCLES−1, clear it and go to STEP.
- **STEP:** x += vx; y += vy using the old vy; then vy += 1 (gravity). Go to CHECK.
- **CHECK:** tests the new x/y in this priority order (first match wins):
  1. Target box of the non-throwing player → DONE, `hit` = 1.
  2. Wall box → DONE, `hit` = 0.
  3. y ≥ GROUND_Y → DONE, `hit` = 0.
  4. x < 0 or x > 1023 → DONE, `hit` = 0.
  5. No match → FLY.
- **DONE:** `end_throw` = 1, `proj_visible` = 0, `hit` held, position frozen. When `throw_flag` = 0 is sampled, go to IDLE and clear `end_throw` and `hit`.
- **Arithmetic:**
  - x, y: signed 12 bit.
  - vx: signed 6 bit, range ±2..±17.
  - vy: signed 8 bit, clamped at +63 (no further gravity once vy = 63).
  - No wrap is possible within screen bounds; out-of-screen ends the flight before overflow.
- `power` and `turn` changes during flight are ignored.

## Timing
- Reset values: `proj_x` = 0, `proj_y` = 0, `proj_visible` = 0, `end_throw` = 0, `hit` = 0, state IDLE, counter 0.
- Launch latency: `throw_flag` is sampled high at edge N; `proj_x`, `proj_y` and `proj_visible` are valid after edge N.
- Position updates once per TICK_CYCLES+2 cycles (FLY wait, plus one STEP cycle and one CHECK cycle).
- `end_throw` rises the cycle after CHECK detects a collision. It stays high at least until the thrower drops `throw_flag`, and falls one cycle after `throw_flag` = 0 is sampled.
- A `throw_flag` still high in DONE never triggers a relaunch; re-arming requires a low sample.
- `rst` asserted in any state returns to IDLE with reset values at the next edge. An in-flight throw is discarded and no `end_throw` is issued.

## Structure
- `variable_pkg` additions:
  - state enum `proj_state_t`.
  - Screen width constant 1024.
  - Existing PLAYER_1/PLAYER_2 constants.
- One natural sub-module: `frame_tick` (counter plus compare, parameterised by `TICK_CYCLES`, with a synchronous clear). It is instantiated by this block and reusable by other animators.
- The collision comparators stay inline in CHECK.

## Test plan
All scenarios run with `TICK_CYCLES` = 4.
1. Reset mid-flight, 3 steps in → next edge: all outputs 0, IDLE; no `end_throw` ever rises.
2. Launch at `turn` = 0, `power` = 0 → initial (100,600). First step (100+2, 600−4) = (102,596). Second step (104,593). Flight ends on ground with `hit` = 0. `end_throw` stays high until `throw_flag` drops, then clears the next cycle.
3. Launch at `turn` = 1, `power` = 31 → vx = −17, vy = −35. x decreases by 17 per step.
4. Hit: sweep `power` from a START_X_P1 launch until a flight ends with x ∈ [868,932] and y ≥ 560. Require `hit` = 1, and target priority over ground when both apply in the same CHECK.
5. Wall: low-power launch crossing x ∈ [496,528] with y ≥ 400 → DONE, `hit` = 0, position frozen at the colliding point.
6. Held `throw_flag` after DONE → no relaunch; drop it, then raise it again → a fresh launch from the start position.

Source files
------------

// File: rtl/variable_pkg.sv
// rtl/variable_pkg.sv - shared game constants and the projectile state encoding.
package variable_pkg;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam int SCREEN_W = 1024;

  typedef enum logic [2:0] {
    PROJ_IDLE  = 3'd0,
    PROJ_FLY   = 3'd1,
    PROJ_STEP  = 3'd2,
    PROJ_CHECK = 3'd3,
    PROJ_DONE  = 3'd4
  } proj_state_t;

endpackage

// File: rtl/frame_tick.sv
// rtl/frame_tick.sv - free-running physics-step counter, one-cycle tick every TICK_CYCLES enabled cycles.
module frame_tick #(
  parameter int TICK_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(TICK_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/projectile.sv
// rtl/projectile.sv - launches, animates and collision-checks one thrown projectile.
module projectile
  import variable_pkg::*;
#(
  parameter int TICK_CYCLES = 1_000_000,
  parameter int START_X_P1  = 100,
  parameter int START_X_P2  = 900,
  parameter int START_Y     = 600,
  parameter int GROUND_Y    = 700,
  parameter int WALL_X_MIN  = 496,
  parameter int WALL_X_MAX  = 528,
  parameter int WALL_TOP    = 400,
  parameter int TGT_HALF    = 32,
  parameter int TGT_TOP     = 560
) (
  input  logic               clk60MHz,
  input  logic               rst,
  input  logic               throw_flag,
  input  logic [4:0]         power,
  input  logic               turn,
  output logic signed [11:0] proj_x,
  output logic signed [11:0] proj_y,
  output logic               proj_visible,
  output logic               end_throw,
  output logic               hit
);

  localparam logic signed [11:0] SX1    = 12'(START_X_P1);
  localparam logic signed [11:0] SX2    = 12'(START_X_P2);
  localparam logic signed [11:0] SY     = 12'(START_Y);
  localparam logic signed [11:0] GND    = 12'(GROUND_Y);
  localparam logic signed [11:0] WX_LO  = 12'(WALL_X_MIN);
  localparam logic signed [11:0] WX_HI  = 12'(WALL_X_MAX);
  localparam logic signed [11:0] W_TOP  = 12'(WALL_TOP);
  localparam logic signed [11:0] T_TOP  = 12'(TGT_TOP);
  localparam logic signed [11:0] T1_LO  = 12'(START_X_P1 - TGT_HALF);
  localparam logic signed [11:0] T1_HI  = 12'(START_X_P1 + TGT_HALF);
  localparam logic signed [11:0] T2_LO  = 12'(START_X_P2 - TGT_HALF);
  localparam logic signed [11:0] T2_HI  = 12'(START_X_P2 + TGT_HALF);
  localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - 1);
  localparam logic signed [7:0]  VY_MAX = 8'sd63;

  proj_state_t        state_q, state_d;
  logic signed [11:0] x_q, x_d, y_q, y_d;
  logic signed [5:0]  vx_q, vx_d;
  logic signed [7:0]  vy_q, vy_d;
  logic               turn_q, turn_d;
  logic               vis_q, vis_d, end_q, end_d, hit_q, hit_d;
  logic               launch, tick;
  logic [5:0]         vmag;
  logic               in_tgt, in_wall, on_ground, off_screen;

  frame_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk_i   (clk60MHz),
    .rst_i   (rst),
    .clear_i (launch),
    .en_i    (state_q == PROJ_FLY),
    .tick_o  (tick)
  );

  assign vmag = {2'b00, power[4:1]} + 6'd2;

  // The target under test always belongs to the player who is not throwing.
  assign in_tgt = (turn_q == PLAYER_1)
                  ? (x_q >= T2_LO && x_q <= T2_HI && y_q >= T_TOP && y_q <= GND)
                  : (x_q >= T1_LO && x_q <= T1_HI && y_q >= T_TOP && y_q <= GND);
  assign in_wall    = x_q >= WX_LO && x_q <= WX_HI && y_q >= W_TOP && y_q <= GND;
  assign on_ground  = y_q >= GND;
  assign off_screen = x_q < 0 || x_q > X_MAX;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    turn_d  = turn_q;
    vis_d   = vis_q;
    end_d   = end_q;
    hit_d   = hit_q;
    launch  = 1'b0;
    case (state_q)
      PROJ_IDLE: begin
        end_d = 1'b0;
        vis_d = 1'b0;
        hit_d = 1'b0;
        if (throw_flag) begin
          launch  = 1'b1;
          turn_d  = turn;
          x_d     = (turn == PLAYER_2) ? SX2 : SX1;
          y_d     = SY;
          vx_d    = (turn == PLAYER_2) ? (6'd0 - vmag) : vmag;
          vy_d    = 8'd0 - ({3'b000, power} + 8'd4);
          vis_d   = 1'b1;
          state_d = PROJ_FLY;
        end
      end
      PROJ_FLY: begin
        if (tick) begin
          state_d = PROJ_STEP;
        end
      end
      PROJ_STEP: begin
        x_d     = x_q + {{6{vx_q[5]}}, vx_q};
        y_d     = y_q + {{4{vy_q[7]}}, vy_q};
        vy_d    = (vy_q == VY_MAX) ? vy_q : vy_q + 8'sd1;
        state_d = PROJ_CHECK;
      end
      PROJ_CHECK: begin
        if (in_tgt || in_wall || on_ground || off_screen) begin
          hit_d   = in_tgt;
          end_d   = 1'b1;
          vis_d   = 1'b0;
          state_d = PROJ_DONE;
        end else begin
          state_d = PROJ_FLY;
        end
      end
      PROJ_DONE: begin
        if (!throw_flag) begin
          end_d   = 1'b0;
          hit_d   = 1'b0;
          state_d = PROJ_IDLE;
        end
      end
      default: state_d = PROJ_IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q <= PROJ_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      turn_q  <= 1'b0;
      vis_q   <= 1'b0;
      end_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      turn_q  <= turn_d;
      vis_q   <= vis_d;
      end_q   <= end_d;
      hit_q   <= hit_d;
    end
  end

  assign proj_x       = x_q;
  assign proj_y       = y_q;
  assign proj_visible = vis_q;
  assign end_throw    = end_q;
  assign hit          = hit_q;

endmodule

// File: tb/tb_projectile.sv
// tb/tb_projectile.sv - randomized and directed flights checked against a trajectory-level model.
module tb_projectile;

  localparam int TICK = 4;
  localparam int P    = TICK + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic throw_flag = 1'b0;
  logic turn = 1'b0;
  logic [4:0] power = 5'd0;
  logic signed [11:0] proj_x, proj_y;
  logic proj_visible, end_throw, hit;

  int n_checks = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  projectile #(.TICK_CYCLES(TICK)) dut (
    .clk60MHz     (clk),
    .rst          (rst),
    .throw_flag   (throw_flag),
    .power        (power),
    .turn         (turn),
    .proj_x       (proj_x),
    .proj_y       (proj_y),
    .proj_visible (proj_visible),
    .end_throw    (end_throw),
    .hit          (hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Whole trajectory of one throw: index 0 is the launch point, index m_n the final point.
  int px[$];
  int py[$];
  int m_n;
  bit m_hit;

  task automatic plan(input bit tn, input int pw);
    int x, y, vx, vy, c;
    bit fin;
    px.delete();
    py.delete();
    x  = tn ? 900 : 100;
    y  = 600;
    vx = tn ? -((pw / 2) + 2) : ((pw / 2) + 2);
    vy = -(pw + 4);
    c  = tn ? 100 : 900;
    px.push_back(x);
    py.push_back(y);
    m_hit = 1'b0;
    m_n   = 0;
    fin   = 1'b0;
    while (!fin && m_n < 500) begin
      x = x + vx;
      y = y + vy;
      if (vy < 63) vy = vy + 1;
      m_n++;
      px.push_back(x);
      py.push_back(y);
      if (x >= c - 32 && x <= c + 32 && y >= 560 && y <= 700) begin
        m_hit = 1'b1;
        fin   = 1'b1;
      end else if ((x >= 496 && x <= 528 && y >= 400 && y <= 700) ||
                   y >= 700 || x < 0 || x > 1023) begin
        fin = 1'b1;
      end
    end
  endtask

  int m_mode = 0;
  int m_t = 0;
  int ex = 0, ey = 0;
  bit ev = 1'b0, ee = 1'b0, eh = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0;
      ex = 0;
      ey = 0;
    end else begin
      case (m_mode)
        0: if (throw_flag) begin
          plan(turn, int'(power));
          m_mode = 1;
          m_t = 0;
        end
        1: begin
          m_t++;
          if (m_t == m_n * P) m_mode = 2;
        end
        default: if (!throw_flag) m_mode = 0;
      endcase
    end
    case (m_mode)
      0: begin ev = 1'b0; ee = 1'b0; eh = 1'b0; end
      1: begin
        ex = px[(m_t + 1) / P];
        ey = py[(m_t + 1) / P];
        ev = 1'b1; ee = 1'b0; eh = 1'b0;
      end
      default: begin
        ex = px[m_n];
        ey = py[m_n];
        ev = 1'b0; ee = 1'b1; eh = m_hit;
      end
    endcase
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("proj_x", int'(proj_x), ex);
      chk("proj_y", int'(proj_y), ey);
      chk("proj_visible", int'(proj_visible), int'(ev));
      chk("end_throw", int'(end_throw), int'(ee));
      chk("hit", int'(hit), int'(eh));
    end
  end

  task automatic fly(input bit tn, input int pw, input int hold,
                     output int fx, output int fy, output int fh);
    bit seen;
    turn = tn;
    power = 5'(pw);
    throw_flag = 1'b1;
    @(posedge clk); #1;
    chk("launch_x", int'(proj_x), tn ? 900 : 100);
    chk("launch_y", int'(proj_y), 600);
    chk("launch_vis", int'(proj_visible), 1);
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (end_throw) begin
        seen = 1'b1;
        break;
      end
      power = 5'($urandom);
      turn = 1'($urandom);
    end
    if (!seen) chk("end_timeout", 0, 1);
    fx = int'(proj_x);
    fy = int'(proj_y);
    fh = int'(hit);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    throw_flag = 1'b0;
    @(posedge clk); #1;
    chk("end_clear", int'(end_throw), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int fx, fy, fh;

    plan(1'b0, 0);
    chk("pin_p0_n", m_n, 20);
    chk("pin_p0_x1", px[1], 102);
    chk("pin_p0_y1", py[1], 596);
    chk("pin_p0_x2", px[2], 104);
    chk("pin_p0_y2", py[2], 593);
    chk("pin_p0_end", py[20], 710);
    plan(1'b1, 31);
    chk("pin_p31_x1", px[1], 883);
    chk("pin_p31_y1", py[1], 565);
    plan(1'b0, 24);
    chk("pin_p24_n", m_n, 56);
    chk("pin_p24_hit", int'(m_hit), 1);
    plan(1'b0, 16);
    chk("pin_p16_x", px[m_n], 500);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    chk("reset_x", int'(proj_x), 0);
    chk("reset_end", int'(end_throw), 0);

    turn = 1'b0;
    power = 5'd10;
    throw_flag = 1'b1;
    repeat (3 * P + 2) @(posedge clk);
    #1;
    rst = 1'b1;
    throw_flag = 1'b0;
    @(posedge clk); #1;
    chk("midrst_x", int'(proj_x), 0);
    chk("midrst_y", int'(proj_y), 0);
    chk("midrst_vis", int'(proj_visible), 0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    fly(1'b0, 0, 3, fx, fy, fh);
    chk("ground_x", fx, 140);
    chk("ground_y", fy, 710);
    chk("ground_hit", fh, 0);

    fly(1'b1, 31, 2, fx, fy, fh);

    fly(1'b0, 24, 1, fx, fy, fh);
    chk("target_x", fx, 884);
    chk("target_y", fy, 572);
    chk("target_hit", fh, 1);

    fly(1'b0, 16, 15, fx, fy, fh);
    chk("wall_x", fx, 500);
    chk("wall_y", fy, 580);
    chk("wall_hit", fh, 0);

    for (int p = 0; p < 32; p++) begin
      fly(1'b0, p, int'($urandom_range(0, 3)), fx, fy, fh);
    end
    for (int r = 0; r < 16; r++) begin
      fly(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 5)), fx, fy, fh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
